fetch_pc_ctrl: RTL and testbench

Instruction-fetch PC generator and branch-resolution controller. It sits upstream of the BTB, driving the fetch PC into it, and consumes the BTB's prediction to select the next PC. It also takes resolved control-flow results from EX, detects mispredictions, redirects fetch, flushes younger stages, and produces the BTB update write. The block holds the PC register, the IF/ID pipeline register with prediction metadata, and the branch/misprediction performance counters.

---
 rtl/fetch_pc_ctrl_if.sv | 83 ++++++++
 rtl/fetch_pc_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl_if
// Description : Signal bundle between the fetch PC controller and the blocks
//               around it: the hazard unit (stall), the instruction memory,
//               the BTB (lookup and update), the EX stage (resolved control
//               flow) and the decode stage (IF/ID register, flush).
//
//   Inputs to the controller (driven by the environment):
//     stall_if              hold PC and IF/ID
//     imem_instr            instruction read combinationally at pc
//     btb_predicted_taken   BTB hit for pc
//     btb_predicted_target  BTB target for pc
//     ex_valid / ex_is_ctrl / ex_pc / ex_taken / ex_target
//                           resolved control-flow result from EX
//     ex_pred_taken / ex_pred_target
//                           prediction that travelled with the EX instruction
//   Outputs of the controller:
//     pc, btb_en            fetch address and BTB lookup enable
//     if_id_*               IF/ID pipeline register and prediction metadata
//     flush                 kill younger (ID/EX) contents this cycle
//     upd_branch_pc / upd_taken / upd_target
//                           BTB update write
//     br_count / mispred_count
//                           saturating performance counters
//
//   Modports: master = the controller view, slave = the environment view.
//
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);

  // Environment -> controller
  logic                  stall_if;
  logic [31:0]           imem_instr;
  logic                  btb_predicted_taken;
  logic [ADDR_WIDTH-1:0] btb_predicted_target;
  logic                  ex_valid;
  logic                  ex_is_ctrl;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic                  ex_taken;
  logic [ADDR_WIDTH-1:0] ex_target;
  logic                  ex_pred_taken;
  logic [ADDR_WIDTH-1:0] ex_pred_target;

  // Controller -> environment
  logic [ADDR_WIDTH-1:0] pc;
  logic                  btb_en;
  logic                  if_id_valid;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic [31:0]           if_id_instr;
  logic                  if_id_pred_taken;
  logic [ADDR_WIDTH-1:0] if_id_pred_target;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] upd_branch_pc;
  logic                  upd_taken;
  logic [ADDR_WIDTH-1:0] upd_target;
  logic [CNT_WIDTH-1:0]  br_count;
  logic [CNT_WIDTH-1:0]  mispred_count;

  modport master (
    input  stall_if, imem_instr, btb_predicted_taken, btb_predicted_target,
           ex_valid, ex_is_ctrl, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pc, btb_en, if_id_valid, if_id_pc, if_id_instr,
           if_id_pred_taken, if_id_pred_target, flush,
           upd_branch_pc, upd_taken, upd_target, br_count, mispred_count
  );

  modport slave (
    output stall_if, imem_instr, btb_predicted_taken, btb_predicted_target,
           ex_valid, ex_is_ctrl, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pc, btb_en, if_id_valid, if_id_pc, if_id_instr,
           if_id_pred_taken, if_id_pred_target, flush,
           upd_branch_pc, upd_taken, upd_target, br_count, mispred_count
  );

endinterface : fetch_pc_ctrl_if
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Instruction-fetch PC generator and branch-resolution
//               controller. Holds the fetch PC, the IF/ID register with the
//               BTB prediction that was used for each fetched instruction,
//               and branch / misprediction counters. Compares the resolved
//               outcome arriving from EX against the prediction carried with
//               it, redirects fetch and flushes younger stages on a
//               misprediction, and forms the BTB update write.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-low reset
//     bus    fetch_pc_ctrl_if.master (see interface header for members)
//
//   Parameters:
//     ADDR_WIDTH  PC / target width
//     RESET_PC    fetch address after reset
//     CNT_WIDTH   performance counter width
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  wire                   clk,
  input  wire                   reset,
  fetch_pc_ctrl_if.master       bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [ADDR_WIDTH-1:0] c_PC_STEP    = ADDR_WIDTH'(4);
  // Instruction addresses are word aligned: bits [1:0] are always cleared.
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX    = '1;

  // --------------------------------------------------------------------------
  // Control FSM
  // BOOT holds the reset PC for one cycle with the BTB disabled; RUN fetches.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  logic   r_btb_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_BOOT;
      r_btb_en <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state  <= ST_RUN;
          r_btb_en <= 1'b1;
        end
        ST_RUN: begin
          r_state  <= ST_RUN;
          r_btb_en <= 1'b1;
        end
        default: begin
          r_state  <= ST_BOOT;
          r_btb_en <= 1'b0;
        end
      endcase
    end
  end

  logic w_run;
  assign w_run = (r_state == ST_RUN);

  // --------------------------------------------------------------------------
  // Misprediction detection and redirect target
  // --------------------------------------------------------------------------
  logic                  w_ctrl_taken;
  logic                  w_dir_wrong;
  logic                  w_tgt_wrong;
  logic                  w_false_hit;
  logic                  w_mispredict;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  assign w_ctrl_taken = bus.ex_is_ctrl & bus.ex_taken;

  // Direction disagreed with the prediction.
  assign w_dir_wrong  = bus.ex_is_ctrl & (bus.ex_taken != bus.ex_pred_taken);

  // Direction right (taken) but the BTB pointed somewhere else, e.g. a jalr
  // whose register target changed since the BTB entry was written.
  assign w_tgt_wrong  = w_ctrl_taken & bus.ex_pred_taken &
                        (bus.ex_target != bus.ex_pred_target);

  // BTB hit on something that turned out not to be a control instruction
  // (aliasing); fetch went off-path and must resume sequentially.
  assign w_false_hit  = ~bus.ex_is_ctrl & bus.ex_pred_taken;

  assign w_mispredict = bus.ex_valid & (w_dir_wrong | w_tgt_wrong | w_false_hit);

  // Correct path: taken target, otherwise the instruction after the EX one.
  assign w_redirect_pc = w_ctrl_taken ? bus.ex_target : (bus.ex_pc + c_PC_STEP);

  // --------------------------------------------------------------------------
  // Next-PC selection
  // Priority: mispredict > stall > BTB prediction > sequential.
  // In BOOT the reset PC is held so that it is the first address fetched.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  always_comb begin
    w_next_pc = r_pc;
    if (w_run) begin
      if (w_mispredict) begin
        w_next_pc = w_redirect_pc;
      end else if (bus.stall_if) begin
        w_next_pc = r_pc;
      end else if (bus.btb_predicted_taken) begin
        w_next_pc = bus.btb_predicted_target;
      end else begin
        w_next_pc = r_pc + c_PC_STEP;
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC and IF/ID registers
  // --------------------------------------------------------------------------
  logic                  r_if_id_valid;
  logic [ADDR_WIDTH-1:0] r_if_id_pc;
  logic [31:0]           r_if_id_instr;
  logic                  r_if_id_pred_taken;
  logic [ADDR_WIDTH-1:0] r_if_id_pred_target;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc                <= RESET_PC & c_ALIGN_MASK;
      r_if_id_valid       <= 1'b0;
      r_if_id_pc          <= '0;
      r_if_id_instr       <= '0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= '0;
    end else begin
      r_pc <= w_next_pc & c_ALIGN_MASK;

      // Nothing is captured in BOOT; the fetch at the reset PC happens in the
      // first RUN cycle.
      if (w_run) begin
        if (w_mispredict) begin
          // Instruction currently in IF is on the wrong path. Only the valid
          // bit matters; the payload is left as is.
          r_if_id_valid <= 1'b0;
        end else if (!bus.stall_if) begin
          r_if_id_valid       <= 1'b1;
          r_if_id_pc          <= r_pc;
          r_if_id_instr       <= bus.imem_instr;
          r_if_id_pred_taken  <= bus.btb_predicted_taken;
          r_if_id_pred_target <= bus.btb_predicted_target;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_br_count;
  logic [CNT_WIDTH-1:0] r_mispred_count;
  logic                 w_br_event;

  assign w_br_event = bus.ex_valid & bus.ex_is_ctrl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_br_event && (r_br_count != c_CNT_MAX)) begin
        r_br_count <= r_br_count + 1'b1;
      end
      if (w_mispredict && (r_mispred_count != c_CNT_MAX)) begin
        r_mispred_count <= r_mispred_count + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc                = r_pc;
  assign bus.btb_en            = r_btb_en;
  assign bus.if_id_valid       = r_if_id_valid;
  assign bus.if_id_pc          = r_if_id_pc;
  assign bus.if_id_instr       = r_if_id_instr;
  assign bus.if_id_pred_taken  = r_if_id_pred_taken;
  assign bus.if_id_pred_target = r_if_id_pred_target;

  assign bus.flush             = w_mispredict;

  // BTB write: every resolved instruction updates its entry; only taken
  // control flow is recorded as taken.
  assign bus.upd_branch_pc     = bus.ex_pc;
  assign bus.upd_target        = bus.ex_target;
  assign bus.upd_taken         = bus.ex_valid & w_ctrl_taken;

  assign bus.br_count          = r_br_count;
  assign bus.mispred_count     = r_mispred_count;

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Directed bench for fetch_pc_ctrl. A table of single-cycle
//               vectors covers sequential fetch, BTB redirect, each kind of
//               misprediction and stall priority; hand-written sequences
//               cover boot, stall around a mispredict, PC wrap, reset during
//               operation and counter saturation (CNT_WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;

  logic clk;
  logic reset;

  fetch_pc_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  fetch_pc_ctrl #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (32'h0000_0100),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic c, input logic [31:0] epc,
                        input logic t, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    bus.ex_valid       = v;
    bus.ex_is_ctrl     = c;
    bus.ex_pc          = epc;
    bus.ex_taken       = t;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic clear_inputs();
    bus.stall_if             = 1'b0;
    bus.imem_instr           = '0;
    bus.btb_predicted_taken  = 1'b0;
    bus.btb_predicted_target = '0;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic        stall;
    logic        btb_t;
    logic [31:0] btb_tgt;
    logic [31:0] imem;
    logic        exv;
    logic        exc;
    logic [31:0] expc;
    logic        ext;
    logic [31:0] extgt;
    logic        expt;
    logic [31:0] exptgt;
    logic        e_flush;
    logic        e_upd;
    logic [31:0] e_pc;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic [31:0] e_ifinstr;
    logic        e_ifpt;
    logic [31:0] e_ifptgt;
    logic [3:0]  e_br;
    logic [3:0]  e_mis;
  } vec_t;

  vec_t vec [15];

  initial begin
    n_vec  = 0;
    n_fail = 0;

    // stall btb btb_tgt imem | exv exc expc ext extgt expt exptgt |
    // flush upd | pc | ifv ifpc ifinstr ifpt ifptgt | br mis
    vec[0]  = '{0,0,32'h0,32'hA0, 0,0,32'h0,0,32'h0,0,32'h0,     0,0, 32'h104, 1,32'h100,32'hA0,0,32'h0,   0,0};
    vec[1]  = '{0,0,32'h0,32'hA1, 0,0,32'h0,0,32'h0,0,32'h0,     0,0, 32'h108, 1,32'h104,32'hA1,0,32'h0,   0,0};
    vec[2]  = '{0,1,32'h200,32'hA2, 0,0,32'h0,0,32'h0,0,32'h0,   0,0, 32'h200, 1,32'h108,32'hA2,1,32'h200, 0,0};
    vec[3]  = '{0,0,32'h0,32'hA3, 1,1,32'h40,1,32'h80,0,32'h0,   1,1, 32'h80,  0,32'h0,32'h0,0,32'h0,      1,1};
    vec[4]  = '{0,0,32'h0,32'hA4, 1,1,32'h40,0,32'h0,1,32'h80,   1,0, 32'h44,  0,32'h0,32'h0,0,32'h0,      2,2};
    vec[5]  = '{0,0,32'h0,32'hA5, 1,0,32'h50,0,32'h0,1,32'h60,   1,0, 32'h54,  0,32'h0,32'h0,0,32'h0,      2,3};
    vec[6]  = '{0,0,32'h0,32'hA6, 1,1,32'h60,1,32'h90,1,32'h90,  0,1, 32'h58,  1,32'h54,32'hA6,0,32'h0,    3,3};
    vec[7]  = '{0,0,32'h0,32'hA7, 1,1,32'h70,1,32'hA0,1,32'hB0,  1,1, 32'hA0,  0,32'h0,32'h0,0,32'h0,      4,4};
    vec[8]  = '{0,0,32'h0,32'hA8, 1,1,32'h74,0,32'h0,0,32'h0,    0,0, 32'hA4,  1,32'hA0,32'hA8,0,32'h0,    5,4};
    vec[9]  = '{0,0,32'h0,32'hA9, 0,1,32'h78,1,32'h99C,0,32'h0,  0,0, 32'hA8,  1,32'hA4,32'hA9,0,32'h0,    5,4};
    vec[10] = '{0,0,32'h0,32'hAA, 1,1,32'hC0,1,32'h123,0,32'h0,  1,1, 32'h120, 0,32'h0,32'h0,0,32'h0,      6,5};
    vec[11] = '{1,0,32'h0,32'hAB, 0,0,32'h0,0,32'h0,0,32'h0,     0,0, 32'h120, 0,32'h0,32'h0,0,32'h0,      6,5};
    vec[12] = '{0,0,32'h0,32'hAC, 0,0,32'h0,0,32'h0,0,32'h0,     0,0, 32'h124, 1,32'h120,32'hAC,0,32'h0,   6,5};
    vec[13] = '{1,1,32'h400,32'hAD, 0,0,32'h0,0,32'h0,0,32'h0,   0,0, 32'h124, 1,32'h120,32'hAC,0,32'h0,   6,5};
    vec[14] = '{0,1,32'h400,32'hAE, 0,0,32'h0,0,32'h0,0,32'h0,   0,0, 32'h400, 1,32'h124,32'hAE,1,32'h400, 6,5};

    // ---------------- reset and boot ----------------
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_pc", bus.pc, 32'h100);
    chk("rst_ifv", {31'h0, bus.if_id_valid}, 32'h0);
    chk("rst_ifpc", bus.if_id_pc, 32'h0);
    chk("rst_btb_en", {31'h0, bus.btb_en}, 32'h0);
    chk("rst_br", {28'h0, bus.br_count}, 32'h0);
    chk("rst_mis", {28'h0, bus.mispred_count}, 32'h0);
    reset = 1'b1;
    bus.imem_instr = 32'hDEAD;
    #1;
    chk("boot_btb_en", {31'h0, bus.btb_en}, 32'h0);
    tick();
    chk("run_btb_en", {31'h0, bus.btb_en}, 32'h1);
    chk("run0_pc", bus.pc, 32'h100);
    chk("run0_ifv", {31'h0, bus.if_id_valid}, 32'h0);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 15; i++) begin
      bus.stall_if             = vec[i].stall;
      bus.btb_predicted_taken  = vec[i].btb_t;
      bus.btb_predicted_target = vec[i].btb_tgt;
      bus.imem_instr           = vec[i].imem;
      set_ex(vec[i].exv, vec[i].exc, vec[i].expc, vec[i].ext, vec[i].extgt,
             vec[i].expt, vec[i].exptgt);
      #1;
      chk($sformatf("v%0d_flush", i), {31'h0, bus.flush}, {31'h0, vec[i].e_flush});
      chk($sformatf("v%0d_upd_taken", i), {31'h0, bus.upd_taken}, {31'h0, vec[i].e_upd});
      if (vec[i].exv) begin
        chk($sformatf("v%0d_upd_pc", i), bus.upd_branch_pc, vec[i].expc);
        chk($sformatf("v%0d_upd_tgt", i), bus.upd_target, vec[i].extgt);
      end
      tick();
      chk($sformatf("v%0d_pc", i), bus.pc, vec[i].e_pc);
      chk($sformatf("v%0d_ifv", i), {31'h0, bus.if_id_valid}, {31'h0, vec[i].e_ifv});
      if (vec[i].e_ifv) begin
        chk($sformatf("v%0d_ifpc", i), bus.if_id_pc, vec[i].e_ifpc);
        chk($sformatf("v%0d_ifinstr", i), bus.if_id_instr, vec[i].e_ifinstr);
        chk($sformatf("v%0d_ifpt", i), {31'h0, bus.if_id_pred_taken}, {31'h0, vec[i].e_ifpt});
        chk($sformatf("v%0d_ifptgt", i), bus.if_id_pred_target, vec[i].e_ifptgt);
      end
      chk($sformatf("v%0d_br", i), {28'h0, bus.br_count}, {28'h0, vec[i].e_br});
      chk($sformatf("v%0d_mis", i), {28'h0, bus.mispred_count}, {28'h0, vec[i].e_mis});
    end

    // ---------------- stall x3 with mispredict in cycle 2 ----------------
    clear_inputs();
    bus.stall_if = 1'b1;
    bus.imem_instr = 32'hB1;
    tick();
    chk("st1_pc", bus.pc, 32'h400);
    chk("st1_ifpc", bus.if_id_pc, 32'h124);
    set_ex(1'b1, 1'b1, 32'h10, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    chk("st2_flush", {31'h0, bus.flush}, 32'h1);
    tick();
    chk("st2_pc", bus.pc, 32'h300);
    chk("st2_ifv", {31'h0, bus.if_id_valid}, 32'h0);
    chk("st2_mis", {28'h0, bus.mispred_count}, 32'h6);
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("st3_pc", bus.pc, 32'h300);
    chk("st3_ifv", {31'h0, bus.if_id_valid}, 32'h0);
    bus.stall_if = 1'b0;
    bus.imem_instr = 32'hB4;
    tick();
    chk("st4_pc", bus.pc, 32'h304);
    chk("st4_ifpc", bus.if_id_pc, 32'h300);
    chk("st4_ifv", {31'h0, bus.if_id_valid}, 32'h1);

    // ---------------- PC wrap ----------------
    set_ex(1'b1, 1'b1, 32'h20, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    chk("wrap_redir_pc", bus.pc, 32'hFFFF_FFFC);
    clear_inputs();
    tick();
    chk("wrap_seq_pc", bus.pc, 32'h0);
    chk("wrap_ifpc", bus.if_id_pc, 32'hFFFF_FFFC);
    // False hit at the top address: ex_pc + 4 wraps to 0.
    set_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h500);
    tick();
    chk("wrap_false_hit_pc", bus.pc, 32'h0);

    // ---------------- reset during a mispredict ----------------
    set_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    chk("mrst_pc", bus.pc, 32'h100);
    chk("mrst_br", {28'h0, bus.br_count}, 32'h0);
    chk("mrst_mis", {28'h0, bus.mispred_count}, 32'h0);
    chk("mrst_btb_en", {31'h0, bus.btb_en}, 32'h0);
    reset = 1'b1;
    clear_inputs();
    tick();
    chk("mrst_boot_pc", bus.pc, 32'h100);
    tick();
    chk("mrst_run_pc", bus.pc, 32'h104);
    chk("mrst_run_ifpc", bus.if_id_pc, 32'h100);

    // ---------------- counter saturation (4-bit) ----------------
    set_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    for (int k = 0; k < 14; k++) tick();
    chk("sat14_mis", {28'h0, bus.mispred_count}, 32'hE);
    tick();
    chk("sat15_mis", {28'h0, bus.mispred_count}, 32'hF);
    chk("sat15_br", {28'h0, bus.br_count}, 32'hF);
    tick();
    chk("sat16_mis", {28'h0, bus.mispred_count}, 32'hF);
    chk("sat16_br", {28'h0, bus.br_count}, 32'hF);
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_fetch_pc_ctrl
`default_nettype wire
